// File: rtl/if_fetch_stage_pkg.sv
// Shared types, defaults and small helpers for the instruction-fetch stage.
package if_fetch_stage_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;  // addi x0,x0,0

    // Fetch controller states
    typedef enum logic [1:0] {
        S_BOOT = 2'b00,
        S_REQ  = 2'b01,
        S_WAIT = 2'b10,
        S_HOLD = 2'b11
    } fetch_state_e;

    // Force a byte address onto a word boundary (low two bits cleared)
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], addr[1:0] & 2'b00};
    endfunction

    // Sequential next PC; plain 32-bit modulo add so 0xFFFF_FFFC wraps to 0
    function automatic logic [31:0] pc_incr(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/response channel: single outstanding request,
// req&ready accepts, rvalid/rdata return the word one or more cycles later.
interface if_fetch_stage_if;
    logic        req;
    logic [31:0] addr;
    logic        ready;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (output req, output addr, input ready, input rvalid, input rdata);
    modport slave  (input req, input addr, output ready, output rvalid, output rdata);
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage. Owns the PC, issues one request at a time to
// instruction memory and presents the fetched word to IF/ID. Because IF/ID
// has no valid bit, any cycle without a real instruction presents NOP_INST.
// A redirect during an outstanding request arms kill so the stale response
// is dropped when it eventually arrives.
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    stall_i,
    input  logic                    redirect_i,
    input  logic [31:0]             redirect_pc_i,
    if_fetch_stage_if.master        imem,
    output logic [31:0]             IF_pc,
    output logic [31:0]             IF_inst,
    output logic                    IF_valid
);

    fetch_state_e state_r, state_s;
    logic [31:0]  pc_r, pc_s;
    logic         kill_r, kill_s;
    logic         req_r;
    logic [31:0]  addr_r;
    logic [31:0]  if_pc_r, if_pc_s;
    logic [31:0]  if_inst_r, if_inst_s;
    logic         if_valid_r, if_valid_s;
    logic [31:0]  target_s;

    // Next-state, next-PC and presented-instruction selection
    always_comb begin
        state_s    = state_r;
        pc_s       = pc_r;
        kill_s     = kill_r;
        if_pc_s    = if_pc_r;
        if_inst_s  = NOP_INST;     // bubble unless something real is captured/held
        if_valid_s = 1'b0;
        target_s   = align_word(redirect_pc_i);

        case (state_r)
            S_BOOT: begin
                state_s = S_REQ;
                if (redirect_i) begin
                    pc_s = target_s;
                end else begin
                    pc_s = pc_r;
                end
            end
            S_REQ: begin
                if (imem.ready) begin
                    state_s = S_WAIT;
                    kill_s  = redirect_i;   // accepted fetch is already stale
                end else begin
                    state_s = S_REQ;
                end
                if (redirect_i) begin
                    pc_s = target_s;
                end else begin
                    pc_s = pc_r;
                end
            end
            S_WAIT: begin
                if (redirect_i) begin
                    pc_s = target_s;
                    if (imem.rvalid) begin
                        kill_s  = 1'b0;
                        state_s = S_REQ;
                    end else begin
                        kill_s  = 1'b1;
                        state_s = S_WAIT;
                    end
                end else if (imem.rvalid) begin
                    if (kill_r) begin
                        kill_s  = 1'b0;
                        state_s = S_REQ;
                    end else begin
                        if_pc_s    = pc_r;
                        if_inst_s  = imem.rdata;
                        if_valid_s = 1'b1;
                        if (stall_i) begin
                            state_s = S_HOLD;
                        end else begin
                            pc_s    = pc_incr(pc_r);
                            state_s = S_REQ;
                        end
                    end
                end else begin
                    state_s = S_WAIT;
                end
            end
            S_HOLD: begin
                if (redirect_i) begin
                    pc_s    = target_s;      // held word dropped via bubble defaults
                    state_s = S_REQ;
                end else if (stall_i) begin
                    if_inst_s  = if_inst_r;
                    if_valid_s = if_valid_r;
                end else begin
                    pc_s    = pc_incr(pc_r);
                    state_s = S_REQ;
                end
            end
            default: begin
                state_s = S_BOOT;
            end
        endcase
    end

    // Controller state: FSM state, PC and kill flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_BOOT;
            pc_r    <= RESET_PC;
            kill_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            pc_r    <= pc_s;
            kill_r  <= kill_s;
        end
    end

    // Registered memory request and IF/ID-facing outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_r      <= 1'b0;
            addr_r     <= RESET_PC;
            if_pc_r    <= 32'h0000_0000;
            if_inst_r  <= NOP_INST;
            if_valid_r <= 1'b0;
        end else begin
            req_r      <= (state_s == S_REQ);
            addr_r     <= pc_s;
            if_pc_r    <= if_pc_s;
            if_inst_r  <= if_inst_s;
            if_valid_r <= if_valid_s;
        end
    end

    assign imem.req  = req_r;
    assign imem.addr = addr_r;
    assign IF_pc     = if_pc_r;
    assign IF_inst   = if_inst_r;
    assign IF_valid  = if_valid_r;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: inputs driven and outputs sampled on the
// falling edge; a tiny zero-wait memory responder lives in tick().
module tb_if_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] IF_pc;
    logic [31:0] IF_inst;
    logic        IF_valid;
    logic        mem_auto;
    int          n_cmp;
    int          n_err;

    if_fetch_stage_if imem();

    if_fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INST(32'h0000_0013)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem          (imem),
        .IF_pc         (IF_pc),
        .IF_inst       (IF_inst),
        .IF_valid      (IF_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One clock; in auto mode respond one cycle after accept with 0xA0+addr
    task automatic tick();
        logic        hs;
        logic [31:0] a;
        hs = imem.req & imem.ready;
        a  = imem.addr;
        @(posedge clk);
        @(negedge clk);
        if (mem_auto) begin
            imem.rvalid = hs;
            imem.rdata  = hs ? (32'h0000_00A0 + a) : 32'h0000_0000;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;
        imem.ready = 1'b1; imem.rvalid = 1'b0; imem.rdata = 32'h0; mem_auto = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if ({imem.req, imem.addr} !== {1'b0, 32'h0000_0000}) begin
            n_err++; $display("FAIL reset_req: got %h expected %h", {imem.req, imem.addr}, {1'b0, 32'h0});
        end
        n_cmp++;
        if ({IF_valid, IF_pc, IF_inst} !== {1'b0, 32'h0000_0000, NOP}) begin
            n_err++; $display("FAIL reset_if: got %h expected %h", {IF_valid, IF_pc, IF_inst}, {1'b0, 32'h0, NOP});
        end
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if ({imem.req, imem.addr} !== {1'b1, 32'h0000_0000}) begin
            n_err++; $display("FAIL boot_one_cycle: got %h expected %h", {imem.req, imem.addr}, {1'b1, 32'h0});
        end
    endtask

    task automatic test_sequential();
        logic [31:0] a;
        for (int k = 0; k < 2; k++) begin
            a = 32'(k) * 32'd4;
            n_cmp++;
            if ({imem.req, imem.addr} !== {1'b1, a}) begin
                n_err++; $display("FAIL seq_req k=%0d: got %h expected %h", k, {imem.req, imem.addr}, {1'b1, a});
            end
            tick();
            n_cmp++;
            if ({IF_valid, IF_inst, imem.req} !== {1'b0, NOP, 1'b0}) begin
                n_err++; $display("FAIL seq_bubble k=%0d: got %h expected %h", k, {IF_valid, IF_inst, imem.req}, {1'b0, NOP, 1'b0});
            end
            tick();
            n_cmp++;
            if ({IF_valid, IF_pc, IF_inst} !== {1'b1, a, 32'h0000_00A0 + a}) begin
                n_err++; $display("FAIL seq_inst k=%0d: got %h expected %h", k, {IF_valid, IF_pc, IF_inst}, {1'b1, a, 32'h0000_00A0 + a});
            end
        end
    endtask

    task automatic test_stall();
        n_cmp++;
        if ({imem.req, imem.addr} !== {1'b1, 32'h0000_0008}) begin
            n_err++; $display("FAIL stall_pre_req: got %h expected %h", {imem.req, imem.addr}, {1'b1, 32'h8});
        end
        tick();
        stall_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_cmp++;
            if ({IF_valid, IF_pc, IF_inst, imem.req} !== {1'b1, 32'h0000_0008, 32'h0000_00A8, 1'b0}) begin
                n_err++; $display("FAIL stall_hold c=%0d: got %h expected %h", c, {IF_valid, IF_pc, IF_inst, imem.req}, {1'b1, 32'h8, 32'hA8, 1'b0});
            end
        end
        stall_i = 1'b0;
        tick();
        n_cmp++;
        if ({imem.req, imem.addr, IF_valid} !== {1'b1, 32'h0000_000C, 1'b0}) begin
            n_err++; $display("FAIL stall_release: got %h expected %h", {imem.req, imem.addr, IF_valid}, {1'b1, 32'hC, 1'b0});
        end
    endtask

    task automatic test_redirect_wait();
        tick();
        tick();
        n_cmp++;
        if ({IF_valid, IF_pc, IF_inst, imem.addr} !== {1'b1, 32'h0000_000C, 32'h0000_00AC, 32'h0000_0010}) begin
            n_err++; $display("FAIL rdw_fetch_c: got %h expected %h", {IF_valid, IF_pc, IF_inst, imem.addr}, {1'b1, 32'hC, 32'hAC, 32'h10});
        end
        mem_auto = 1'b0; imem.rvalid = 1'b0;
        tick();
        redirect_i = 1'b1; redirect_pc_i = 32'h0000_0103;
        tick();
        redirect_i = 1'b0;
        n_cmp++;
        if ({imem.req, IF_valid} !== {1'b0, 1'b0}) begin
            n_err++; $display("FAIL rdw_waiting: got %b expected %b", {imem.req, IF_valid}, 2'b00);
        end
        imem.rvalid = 1'b1; imem.rdata = 32'hDEAD_0010;
        tick();
        imem.rvalid = 1'b0; imem.rdata = 32'h0; mem_auto = 1'b1;
        n_cmp++;
        if ({IF_valid, IF_inst, IF_pc, imem.req, imem.addr} !== {1'b0, NOP, 32'h0000_000C, 1'b1, 32'h0000_0100}) begin
            n_err++; $display("FAIL rdw_discard: got %h expected %h", {IF_valid, IF_inst, IF_pc, imem.req, imem.addr}, {1'b0, NOP, 32'hC, 1'b1, 32'h100});
        end
        tick();
        tick();
        n_cmp++;
        if ({IF_valid, IF_pc, IF_inst} !== {1'b1, 32'h0000_0100, 32'h0000_01A0}) begin
            n_err++; $display("FAIL rdw_target: got %h expected %h", {IF_valid, IF_pc, IF_inst}, {1'b1, 32'h100, 32'h1A0});
        end
    endtask

    task automatic test_redirect_corners();
        // redirect coinciding with rvalid
        tick();
        redirect_i = 1'b1; redirect_pc_i = 32'h0000_0200;
        tick();
        redirect_i = 1'b0;
        n_cmp++;
        if ({IF_valid, IF_inst, imem.req, imem.addr} !== {1'b0, NOP, 1'b1, 32'h0000_0200}) begin
            n_err++; $display("FAIL rdv_discard: got %h expected %h", {IF_valid, IF_inst, imem.req, imem.addr}, {1'b0, NOP, 1'b1, 32'h200});
        end
        tick();
        tick();
        n_cmp++;
        if ({IF_valid, IF_pc, IF_inst} !== {1'b1, 32'h0000_0200, 32'h0000_02A0}) begin
            n_err++; $display("FAIL rdv_target: got %h expected %h", {IF_valid, IF_pc, IF_inst}, {1'b1, 32'h200, 32'h2A0});
        end
        // redirect in the same cycle the request is accepted
        redirect_i = 1'b1; redirect_pc_i = 32'h0000_0300;
        tick();
        redirect_i = 1'b0;
        n_cmp++;
        if ({imem.req, IF_valid} !== {1'b0, 1'b0}) begin
            n_err++; $display("FAIL rda_wait: got %b expected %b", {imem.req, IF_valid}, 2'b00);
        end
        tick();
        n_cmp++;
        if ({IF_valid, IF_inst, imem.req, imem.addr} !== {1'b0, NOP, 1'b1, 32'h0000_0300}) begin
            n_err++; $display("FAIL rda_kill: got %h expected %h", {IF_valid, IF_inst, imem.req, imem.addr}, {1'b0, NOP, 1'b1, 32'h300});
        end
        tick();
        tick();
        n_cmp++;
        if ({IF_valid, IF_pc, IF_inst} !== {1'b1, 32'h0000_0300, 32'h0000_03A0}) begin
            n_err++; $display("FAIL rda_target: got %h expected %h", {IF_valid, IF_pc, IF_inst}, {1'b1, 32'h300, 32'h3A0});
        end
        // redirect while holding a stalled instruction
        tick();
        stall_i = 1'b1;
        tick();
        n_cmp++;
        if ({IF_valid, IF_pc, IF_inst, imem.req} !== {1'b1, 32'h0000_0304, 32'h0000_03A4, 1'b0}) begin
            n_err++; $display("FAIL rdh_held: got %h expected %h", {IF_valid, IF_pc, IF_inst, imem.req}, {1'b1, 32'h304, 32'h3A4, 1'b0});
        end
        redirect_i = 1'b1; redirect_pc_i = 32'h0000_0040;
        tick();
        redirect_i = 1'b0; stall_i = 1'b0;
        n_cmp++;
        if ({IF_valid, IF_inst, IF_pc, imem.req, imem.addr} !== {1'b0, NOP, 32'h0000_0304, 1'b1, 32'h0000_0040}) begin
            n_err++; $display("FAIL rdh_drop: got %h expected %h", {IF_valid, IF_inst, IF_pc, imem.req, imem.addr}, {1'b0, NOP, 32'h304, 1'b1, 32'h40});
        end
        tick();
        tick();
        n_cmp++;
        if ({IF_valid, IF_pc, IF_inst} !== {1'b1, 32'h0000_0040, 32'h0000_00E0}) begin
            n_err++; $display("FAIL rdh_target: got %h expected %h", {IF_valid, IF_pc, IF_inst}, {1'b1, 32'h40, 32'hE0});
        end
    endtask

    task automatic test_wrap();
        imem.ready = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFF;
        tick();
        redirect_i = 1'b0;
        n_cmp++;
        if ({imem.req, imem.addr} !== {1'b1, 32'hFFFF_FFFC}) begin
            n_err++; $display("FAIL wrap_redirect: got %h expected %h", {imem.req, imem.addr}, {1'b1, 32'hFFFF_FFFC});
        end
        tick();
        n_cmp++;
        if ({imem.req, imem.addr, IF_valid} !== {1'b1, 32'hFFFF_FFFC, 1'b0}) begin
            n_err++; $display("FAIL wrap_req_stable: got %h expected %h", {imem.req, imem.addr, IF_valid}, {1'b1, 32'hFFFF_FFFC, 1'b0});
        end
        imem.ready = 1'b1;
        tick();
        tick();
        n_cmp++;
        if ({IF_valid, IF_pc, IF_inst, imem.req, imem.addr} !== {1'b1, 32'hFFFF_FFFC, 32'h0000_009C, 1'b1, 32'h0000_0000}) begin
            n_err++; $display("FAIL wrap_next: got %h expected %h", {IF_valid, IF_pc, IF_inst, imem.req, imem.addr}, {1'b1, 32'hFFFF_FFFC, 32'h9C, 1'b1, 32'h0});
        end
    endtask

    task automatic test_reset_mid();
        tick();
        mem_auto = 1'b0; imem.rvalid = 1'b0; imem.rdata = 32'h0;
        n_cmp++;
        if ({imem.req, IF_pc} !== {1'b0, 32'hFFFF_FFFC}) begin
            n_err++; $display("FAIL rmid_waiting: got %h expected %h", {imem.req, IF_pc}, {1'b0, 32'hFFFF_FFFC});
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({imem.req, imem.addr, IF_valid, IF_pc, IF_inst} !== {1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, NOP}) begin
            n_err++; $display("FAIL rmid_async: got %h expected %h", {imem.req, imem.addr, IF_valid, IF_pc, IF_inst}, {1'b0, 32'h0, 1'b0, 32'h0, NOP});
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1; imem.ready = 1'b0;
        tick();
        n_cmp++;
        if ({imem.req, imem.addr} !== {1'b1, 32'h0000_0000}) begin
            n_err++; $display("FAIL rmid_first_req: got %h expected %h", {imem.req, imem.addr}, {1'b1, 32'h0});
        end
        imem.rvalid = 1'b1; imem.rdata = 32'hBAD0_0004;
        tick();
        tick();
        n_cmp++;
        if ({IF_valid, IF_inst, imem.req, imem.addr} !== {1'b0, NOP, 1'b1, 32'h0000_0000}) begin
            n_err++; $display("FAIL rmid_stray: got %h expected %h", {IF_valid, IF_inst, imem.req, imem.addr}, {1'b0, NOP, 1'b1, 32'h0});
        end
        imem.rvalid = 1'b0; imem.rdata = 32'h0; imem.ready = 1'b1; mem_auto = 1'b1;
        tick();
        tick();
        n_cmp++;
        if ({IF_valid, IF_pc, IF_inst} !== {1'b1, 32'h0000_0000, 32'h0000_00A0}) begin
            n_err++; $display("FAIL rmid_refetch: got %h expected %h", {IF_valid, IF_pc, IF_inst}, {1'b1, 32'h0, 32'hA0});
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_wait();
        test_redirect_corners();
        test_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
